// File: rtl/mult_pkg.sv
// Shared types and width helpers for the mult_n shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The product register is always twice the operand width.
    localparam int PROD_FACTOR = 2;

    function automatic int prod_w(input int w);
        return PROD_FACTOR * w;
    endfunction

endpackage

// File: rtl/mult_n_if.sv
// Start/operand/result bundle between a controller (master) and mult_n (slave).
interface mult_n_if
    import mult_pkg::*;
#(
    parameter int W = 4
);
    logic                 init;
    logic [W-1:0]         A;
    logic [W-1:0]         B;
    logic [prod_w(W)-1:0] pp;
    logic                 done;
    logic                 busy;

    modport master (output init, A, B, input  pp, done, busy);
    modport slave  (input  init, A, B, output pp, done, busy);
endinterface

// File: rtl/mult_n_ctrl.sv
// IDLE/RUN/DONE sequencer for mult_n. init is only looked at in IDLE;
// RUN ends on the edge where the shifted multiplier runs out of set bits.
module mult_n_ctrl
    import mult_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic zero_nxt,
    output logic load,
    output logic run,
    output logic done,
    output logic busy
);
    state_t state_q, state_d;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and Moore outputs; load is the accepting-edge strobe.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        run     = 1'b0;
        done    = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (init) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run  = 1'b1;
                busy = 1'b1;
                if (zero_nxt) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/mult_n.sv
// W x W -> 2W sequential shift-add multiplier, one multiplier bit per clock,
// early exit once the remaining multiplier bits are zero.
// Optional build macro MULT_SIGNED_EN: operands and product are two's
// complement; magnitudes are multiplied and the sign applied on the last edge.
module mult_n
    import mult_pkg::*;
#(
    parameter int W = 4
) (
    input  logic      clk,
    input  logic      rst,
    mult_n_if.slave   bus
);
    localparam int PW = prod_w(W);

    logic [PW-1:0] a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [PW-1:0] pp_q, pp_d;
    logic          sign_q, sign_d;

    logic [W-1:0]  mag_a, mag_b;
    logic          sign_ld;
    logic [PW-1:0] term, sum, sum_neg;
    logic          zero_nxt, load, run, done, busy;

`ifdef MULT_SIGNED_EN
    // -2^(W-1) negates to itself, which read unsigned is the right magnitude.
    assign mag_a   = bus.A[W-1] ? (~bus.A + W'(1)) : bus.A;
    assign mag_b   = bus.B[W-1] ? (~bus.B + W'(1)) : bus.B;
    assign sign_ld = bus.A[W-1] ^ bus.B[W-1];
`else
    assign mag_a   = bus.A;
    assign mag_b   = bus.B;
    assign sign_ld = 1'b0;
`endif

    assign term     = b_sh_q[0] ? a_sh_q : '0;
    assign sum      = pp_q + term;
    assign sum_neg  = ~sum + PW'(1);
    assign zero_nxt = (b_sh_q >> 1) == '0;

    mult_n_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .init     (bus.init),
        .zero_nxt (zero_nxt),
        .load     (load),
        .run      (run),
        .done     (done),
        .busy     (busy)
    );

    // Datapath next-state: load operands, or accumulate and shift while running.
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        pp_d   = pp_q;
        sign_d = sign_q;
        if (load) begin
            a_sh_d = {{W{1'b0}}, mag_a};
            b_sh_d = mag_b;
            pp_d   = '0;
            sign_d = sign_ld;
        end else if (run) begin
            // Negating zero gives zero, so a zero product stays 0 with sign set.
            pp_d   = (zero_nxt && sign_q) ? sum_neg : sum;
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            pp_q   <= '0;
            sign_q <= 1'b0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            pp_q   <= pp_d;
            sign_q <= sign_d;
        end
    end

    assign bus.pp   = pp_q;
    assign bus.done = done;
    assign bus.busy = busy;
endmodule

// File: doc/mult_n.md
# mult_n

Parametrised sequential shift-add multiplier, W×W → 2W bits, the W-generic successor to the fixed 4-bit multiplier. It processes one multiplier bit per clock and terminates early once the remaining multiplier bits are zero. It exposes a busy/done handshake to the controlling logic and has an optional compile-time signed mode.

## Interface
- W, default 4: operand width in bits; legal W ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- init  input  1  start request; sampled only in IDLE.
- A  input  W  multiplicand; sampled on the accepting edge.
- B  input  W  multiplier; sampled on the accepting edge.
- pp  output  2W  product / accumulator register.
- done  output  1  one-cycle pulse; pp holds the final product while it is high.
- busy  output  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE. Each state is held in registers; done and busy are Moore outputs.
- IDLE, init=1 (accepting edge):
  - a_sh (2W) ← zero-extended A.
  - b_sh (W) ← B.
  - pp ← 0.
  - sign ← 0.
  - Next state RUN.
- IDLE, init=0: hold. pp keeps the last product.
- RUN, every edge:
  - pp ← pp + (b_sh[0] ? a_sh : 0).
  - a_sh ← a_sh << 1.
  - b_sh ← b_sh >> 1.
  - If (b_sh >> 1) == 0, next state DONE; else stay in RUN.
- DONE: done=1 for one cycle. Next state IDLE unconditionally.
- init is ignored in RUN and DONE; no queuing. If init is held high, a new operation is accepted on the first IDLE edge after DONE.
- Arithmetic: 2W-bit unsigned. Overflow is impossible because (2^W−1)² < 2^2W.
- rst at any time:
  - State → IDLE.
  - pp, a_sh, b_sh, sign → 0.
  - done=0, busy=0.
  - An in-flight operation is abandoned and never produces done.

## Timing
- Reset values: pp=0, done=0, busy=0.
- Let k = max(1, index of the highest set bit of the effective B + 1), so 1 ≤ k ≤ W.
- Accepting edge e0: busy rises after e0.
- RUN occupies edges e1..ek. done is high in the cycle after edge ek, i.e. k cycles after e0.
- Back-to-back throughput is k+2 cycles per product. Worst case is W+2.
- pp is stable from done until the next accepting edge.

## Configuration
- MULT_SIGNED_EN undefined: A, B and pp are unsigned.
- MULT_SIGNED_EN defined: A, B and pp are two's complement.
  - On the accepting edge, a_sh ← |A| and b_sh ← |B|, as W-bit unsigned magnitudes; −2^(W−1) maps to 2^(W−1).
  - sign ← A[W−1] ^ B[W−1].
  - On the final RUN edge, pp ← sign ? −(pp + term) : (pp + term), where term is that edge's partial product. Latency is unchanged.
  - k is computed from |B|.
  - A zero product always yields pp=0, including when sign=1.

## Structure
- Package mult_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - a localparam helper for the product width 2W.
- Sub-module mult_n_ctrl: the FSM. Inputs are rst, init and the zero-next flag; outputs are load, run, done and busy.
- The datapath (shift registers, adder, sign handling) stays in mult_n.

## Test plan
- W=4, A=13, B=11 → pp=143 (8'h8F). done exactly 4 cycles after the accepting edge, high for 1 cycle, busy high for 5 cycles.
- W=4, A=7, B=2 → pp=14, done after 2 cycles (early exit). Then A=9, B=0 → pp=0, done after 1 cycle.
- W=4, A=15, B=11, init held high throughout:
  - the second acceptance occurs on the edge after DONE;
  - mid-RUN changes on A and B are ignored;
  - pp=165 on both done pulses.
- W=4, A=15, B=15, rst asserted at the 2nd RUN cycle:
  - next cycle pp=0, busy=0, done never pulses;
  - a subsequent A=15, B=15 gives 225.
- W=8, A=255, B=255 → pp=65025, done after 8 cycles. W=8, A=200, B=1 → pp=200, done after 1 cycle.
- MULT_SIGNED_EN, W=4:
  - −8×−8 → pp=64, done after 4 cycles;
  - −3×5 → pp=8'hF1 (−15), done after 3 cycles;
  - 0×−1 → pp=0.
